// File: rtl/exrom_rd_responder.sv
// Purpose: responder end of the TPU read-request interface; queues requests and
//          answers each from the internal ROM array `rom` after RD_LAT wait cycles.
// Latency: request sampled at edge k -> o_DVALID high in the cycle after edge k+RD_LAT+1;
//          back-to-back throughput is one response per RD_LAT+1 cycles.
// Backpressure: o_BUSY (registered) is high while the queue is full; requests sampled
//          while it is high are dropped with no o_RD_ACK and no response.
// Ports: i_SCLK clock, i_RESET async active-high reset, i_RD_RQST/i_ADDR request in,
//        o_RD_ACK accept pulse, o_BUSY queue full, o_DATA/o_DVALID/o_ERR response.
module exrom_rd_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int RD_LAT  = 2,
  parameter int Q_DEPTH = 2
) (
  input  logic              i_SCLK,
  input  logic              i_RESET,
  input  logic              i_RD_RQST,
  input  logic [ADDR_W-1:0] i_ADDR,
  output logic              o_RD_ACK,
  output logic              o_BUSY,
  output logic [DATA_W-1:0] o_DATA,
  output logic              o_DVALID,
  output logic              o_ERR
);

  localparam int PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int RIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Preloaded by the environment; never reset.
  logic [DATA_W-1:0] rom [0:DEPTH-1];

  logic [ADDR_W-1:0] r_q [0:Q_DEPTH-1];
  logic [PTR_W:0]    r_wptr, r_rptr;
  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_ack, r_busy, r_dvalid, r_err;
  logic              w_dvalid_nxt, w_err_nxt;
  logic              w_push, w_pop, w_empty, w_in_range, w_full_nxt;
  logic [PTR_W:0]    w_wptr_nxt, w_rptr_nxt;
  logic [RIDX_W-1:0] w_rom_idx;

  // A full queue rejects even when a pop happens on the same edge, because
  // acceptance looks only at the registered busy flag.
  assign w_push     = i_RD_RQST & ~r_busy;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_wptr_nxt = r_wptr + (PTR_W+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (PTR_W+1)'(w_pop);
  // Full when the wrap bits differ and the index bits match.
  assign w_full_nxt = (w_wptr_nxt[PTR_W] != w_rptr_nxt[PTR_W]) &&
                      (w_wptr_nxt[PTR_W-1:0] == w_rptr_nxt[PTR_W-1:0]);

  assign w_in_range = ({1'b0, r_addr} < DEPTH_V);
  assign w_rom_idx  = r_addr[RIDX_W-1:0];

  // Queue storage holds only data, so it needs no reset.
  always_ff @(posedge i_SCLK) begin
    if (w_push) r_q[r_wptr[PTR_W-1:0]] <= i_ADDR;
  end

  always_ff @(posedge i_SCLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_ack    <= w_push;
      r_busy   <= w_full_nxt;
      r_dvalid <= w_dvalid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_pop        = 1'b0;
    w_dvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      // RESP shares the pop path with IDLE so back-to-back reads have no bubble.
      S_IDLE, S_RESP: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_addr_nxt  = r_q[r_rptr[PTR_W-1:0]];
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_dvalid_nxt = 1'b1;
          w_err_nxt    = ~w_in_range;
          w_data_nxt   = w_in_range ? rom[w_rom_idx] : '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_RD_ACK = r_ack;
  assign o_BUSY   = r_busy;
  assign o_DATA   = r_data;
  assign o_DVALID = r_dvalid;
  assign o_ERR    = r_err;

endmodule

// File: tb/tb_exrom_rd_responder.sv
// Bench for exrom_rd_responder: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model (request list plus a
// single server that is busy for RD_LAT+1 cycles per read).
module tb_exrom_rd_responder;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 200;
  localparam int RD_LAT  = 2;
  localparam int Q_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rq;
  logic [ADDR_W-1:0] addr;
  logic              ack, busy, dvalid, err;
  logic [DATA_W-1:0] data;

  always #5 clk = ~clk;

  exrom_rd_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .Q_DEPTH(Q_DEPTH)
  ) dut (
    .i_SCLK(clk), .i_RESET(rst), .i_RD_RQST(rq), .i_ADDR(addr),
    .o_RD_ACK(ack), .o_BUSY(busy), .o_DATA(data), .o_DVALID(dvalid), .o_ERR(err)
  );

  // Reference model state
  logic [DATA_W-1:0] rom_m [0:DEPTH-1];
  int                mq[$];
  bit                m_busy;
  int                edge_n, free_edge, resp_edge, cur;
  logic [DATA_W-1:0] m_data;
  bit                m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy    = 1'b0;
    edge_n    = 0;
    free_edge = 0;
    resp_edge = -1;
    cur       = 0;
    m_data    = '0;
    m_err     = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},    {31'b0, ack},    32'd0);
    chk({tag, "_busy"},   {31'b0, busy},   32'd0);
    chk({tag, "_dvalid"}, {31'b0, dvalid}, 32'd0);
    chk({tag, "_err"},    {31'b0, err},    32'd0);
    chk({tag, "_data"},   data,            32'd0);
  endtask

  // Reset asserted away from the clock edge, held across three edges.
  task automatic do_reset();
    rq  = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive request, advance the model by one edge, compare outputs.
  task automatic step(input bit r, input logic [ADDR_W-1:0] a);
    bit acc, dv;
    rq   = r;
    addr = a;
    @(posedge clk);
    edge_n++;
    acc = r && !m_busy;
    dv  = (edge_n == resp_edge);
    if (dv) begin
      m_err  = (cur >= DEPTH);
      m_data = m_err ? '0 : rom_m[cur];
    end else begin
      m_err = 1'b0;
    end
    // The server takes the oldest request only when free; a request pushed
    // on this edge is not yet visible to it.
    if (edge_n >= free_edge && mq.size() > 0) begin
      cur       = mq.pop_front();
      resp_edge = edge_n + RD_LAT;
      free_edge = edge_n + RD_LAT + 1;
    end
    if (acc) mq.push_back(int'(a));
    m_busy = (mq.size() == Q_DEPTH);
    #1;
    chk("ack",    {31'b0, ack},    {31'b0, acc});
    chk("busy",   {31'b0, busy},   {31'b0, m_busy});
    chk("dvalid", {31'b0, dvalid}, {31'b0, dv});
    chk("err",    {31'b0, err},    {31'b0, m_err});
    chk("data",   data,            m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    rst  = 1'b1;
    rq   = 1'b0;
    addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rom_m[i]   = $urandom;
      dut.rom[i] = rom_m[i];
    end
    rom_m[5]   = 32'hA5A5_0005;
    dut.rom[5] = 32'hA5A5_0005;
    rom_m[0]   = 32'h0000_C0DE;
    dut.rom[0] = 32'h0000_C0DE;

    do_reset();

    // Single read at edge 10
    idle(9);
    step(1'b1, 8'h05);
    idle(6);

    // Back-to-back 1,2,3 then one that may be dropped
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);
    idle(14);

    // Saturate the queue so drops occur
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i));
    idle(14);

    // Out of range then address 0
    step(1'b1, 8'hF0);
    idle(4);
    step(1'b1, 8'h00);
    idle(5);
    step(1'b1, 8'hC8);
    step(1'b1, 8'hC7);
    idle(8);

    // Reset during WAIT with a request still queued
    step(1'b1, 8'h07);
    step(1'b1, 8'h09);
    step(1'b0, '0);
    do_reset();
    idle(20);
    step(1'b1, 8'h10);
    idle(5);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exrom_rd_responder.md
Name: exrom_rd_responder

Overview:
- Responder end of the TPU read-request interface: accepts i_RD_RQST/i_ADDR from the TPU fetch side, queues requests, reads an internal ROM array after a fixed programmable latency, returns o_DATA with a one-cycle o_DVALID strobe.
- Replaces a zero-latency external ROM model, so TPU fetch logic is exercised against realistic, back-pressured memory timing.
- ROM array is named `rom`, so benches preload it hierarchically with $readmemb. The array is never reset.

Parameters:
- ADDR_W, 8, request address width
- DATA_W, 32, ROM word width
- DEPTH, 256, ROM words implemented (DEPTH <= 2**ADDR_W)
- RD_LAT, 2, wait cycles per access (legal range 1..15)
- Q_DEPTH, 2, request queue entries (power of two, >= 2)

Ports:
- i_SCLK  in  1  system clock, rising edge
- i_RESET  in  1  asynchronous, active-high reset
- i_RD_RQST  in  1  read request, sampled each rising edge
- i_ADDR  in  ADDR_W  request address, sampled with i_RD_RQST
- o_RD_ACK  out  1  one-cycle pulse: the request sampled at the previous edge was accepted
- o_BUSY  out  1  queue full; requests sampled while high are dropped
- o_DATA  out  DATA_W  read data, valid only while o_DVALID = 1
- o_DVALID  out  1  one-cycle data strobe
- o_ERR  out  1  high with o_DVALID when the address was >= DEPTH

Behaviour:
- Reset (asynchronous): queue emptied; FSM = IDLE; o_RD_ACK, o_BUSY, o_DVALID, o_ERR = 0; o_DATA = 0; wait counter = 0. Reset mid-access discards the in-flight and all queued requests, with no response. rom contents are untouched.
- Accept rule: at an edge where i_RD_RQST = 1 and registered o_BUSY = 0, push i_ADDR and drive o_RD_ACK = 1 for the following cycle. Otherwise the request is dropped and o_RD_ACK stays 0.
- Full queue: a request is rejected even if a pop occurs at the same edge; o_BUSY is registered.
- o_BUSY = 1 exactly when queue occupancy == Q_DEPTH.
- FSM states and transitions:
  - IDLE: if queue non-empty at the edge, pop the head into the address register, load cnt = RD_LAT-1, go to WAIT. A request pushed at edge k is popped at edge k+1 at the earliest.
  - WAIT: if cnt == 0, go to RESP at the next edge, registering o_DATA = rom[addr] (or 0 if addr >= DEPTH), o_ERR = (addr >= DEPTH), o_DVALID = 1. Otherwise cnt decrements.
  - RESP: o_DVALID high for this one cycle. At the next edge, if the queue is non-empty, pop and go to WAIT (cnt = RD_LAT-1) with no IDLE bubble; else go to IDLE. o_DVALID and o_ERR return to 0. o_DATA holds its last value.
- Latency: an isolated request sampled at edge k gives o_DVALID high in the cycle after edge k+RD_LAT+1.
- Throughput: one response per RD_LAT+1 cycles.
- Ordering: responses are returned strictly in request order.
- Push and pop at the same edge (queue not full): both take effect; occupancy is unchanged.
- Queue pointers are log2(Q_DEPTH) bits and wrap modulo Q_DEPTH. An extra wrap bit distinguishes full from empty.
- Out-of-range address: accepted and queued normally; returns data 0 with o_ERR = 1. There is no other error path.
- o_DVALID is never asserted for a dropped request.

Test Plan:
- Reset then idle: assert i_RESET for 3 cycles mid-simulation -> all outputs 0, o_BUSY = 0; no o_DVALID for 20 cycles.
- Single read: RD_LAT=2, rom[8'h05]=32'hA5A5_0005; pulse i_RD_RQST at edge 10 with addr 5 -> o_RD_ACK high after edge 10; o_DVALID high after edge 13 with o_DATA = 32'hA5A5_0005, o_ERR = 0.
- Back-to-back: hold i_RD_RQST for addrs 1,2,3 at edges 10,11,12 (Q_DEPTH=2).
  - Edges 10 and 11: acked.
  - Edge 12: accepted only if registered o_BUSY = 0 at that edge. The bench checks the ack/drop against o_BUSY and expects in-order data.
  - Responses spaced exactly 3 cycles apart.
- Full queue drop: stall with RD_LAT=15 and issue 4 requests -> o_BUSY = 1 after 2 queued; later requests get no o_RD_ACK and no response. o_BUSY clears after the first pop.
- Out of range: DEPTH=200, request addr 8'hF0 -> o_DVALID with o_DATA = 0 and o_ERR = 1. The next request to addr 0 returns rom[0] with o_ERR = 0.
- Reset mid-operation: queue 2 requests, assert i_RESET during WAIT -> no o_DVALID from those requests. A new request after release returns correctly with nominal latency.
